// File: rtl/dpram_pkg.sv
// Shared constants and elaboration helpers for the byte-enable dual-port RAM.
package dpram_pkg;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  function automatic int unsigned nbytes(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic bit cfg_ok(input int unsigned dw, input int unsigned ob);
    return (dw != 0) && ((dw % 8) == 0) && (ob <= 1);
  endfunction

endpackage

// File: rtl/dpram_if.sv
// One RAM port: enable, byte write enables, address, write data and read data.
interface dpram_if
  import dpram_pkg::*;
#(
  parameter int unsigned aw = 10,
  parameter int unsigned dw = 32
);

  logic                  ce;
  logic [nbytes(dw)-1:0] we;
  logic [aw-1:0]         addr;
  logic [dw-1:0]         din;
  logic [dw-1:0]         dout;

  modport master (output ce, output we, output addr, output din, input dout);
  modport slave  (input ce, input we, input addr, input din, output dout);

endinterface

// File: rtl/dpram_clear_seq.sv
// Post-reset zero-fill sequencer: walks every address once, then drops busy.
module dpram_clear_seq #(
  parameter int unsigned aw = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic [aw-1:0] clr_addr,
  output logic          clr_we
);

  logic [aw-1:0] cnt_q;
  logic          done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      cnt_q <= cnt_q + aw'(1);
      if (cnt_q == '1) done_q <= 1'b1;
    end
  end

  assign busy     = rst | ~done_q;
  assign clr_we   = ~rst & ~done_q;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/dpram_be.sv
// True dual-port RAM with byte enables and selectable read-during-write.
// Define DPRAM_CLEAR_EN to compile in the post-reset zero-fill sequencer.
module dpram_be
  import dpram_pkg::*;
#(
  parameter int unsigned aw  = 10,
  parameter int unsigned dw  = 32,
  parameter int unsigned ob  = 0,
  parameter int unsigned rdw = RDW_READ_FIRST
) (
  input  logic    clk,
  input  logic    rst,
  output logic    busy,
  dpram_if.slave  a,
  dpram_if.slave  b
);

  localparam int unsigned nb = nbytes(dw);

  if (!cfg_ok(dw, ob)) begin : g_cfg_err
    $error("dpram_be: dw must be a non-zero multiple of 8 and ob must be 0 or 1");
  end

  logic          clr_we;
  logic [aw-1:0] clr_addr;

`ifdef DPRAM_CLEAR_EN
  dpram_clear_seq #(
    .aw(aw)
  ) u_clear (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .clr_addr(clr_addr),
    .clr_we  (clr_we)
  );
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  logic a_acc, b_acc;
  assign a_acc = a.ce & ~busy & ~rst;
  assign b_acc = b.ce & ~busy & ~rst;

  // The clear sequencer borrows port A's write path.
  logic [nb-1:0] a_wr, b_wr;
  logic [aw-1:0] wa_addr;
  logic [dw-1:0] wa_din;

  always_comb begin
    wa_addr = a.addr;
    wa_din  = a.din;
    a_wr    = a_acc ? a.we : '0;
    b_wr    = b_acc ? b.we : '0;
    if (clr_we) begin
      wa_addr = clr_addr;
      wa_din  = '0;
      a_wr    = '1;
    end
  end

  logic [dw-1:0] mem [2**aw];

  // Port A's lane is assigned last so it wins a same-address byte collision.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < nb; i++) begin
      if (b_wr[i]) mem[b.addr][8*i +: 8] <= b.din[8*i +: 8];
      if (a_wr[i]) mem[wa_addr][8*i +: 8] <= wa_din[8*i +: 8];
    end
  end

  logic [dw-1:0] a_old, b_old, a_mrg, b_mrg, a_rd, b_rd;
  assign a_old = mem[a.addr];
  assign b_old = mem[b.addr];

  // Merge only the port's own write; the other port's write is never visible here.
  always_comb begin
    a_mrg = a_old;
    b_mrg = b_old;
    for (int unsigned i = 0; i < nb; i++) begin
      if (a.we[i]) a_mrg[8*i +: 8] = a.din[8*i +: 8];
      if (b.we[i]) b_mrg[8*i +: 8] = b.din[8*i +: 8];
    end
  end

  assign a_rd = (rdw == RDW_WRITE_FIRST) ? a_mrg : a_old;
  assign b_rd = (rdw == RDW_WRITE_FIRST) ? b_mrg : b_old;

  logic [dw-1:0] a_s0_q, b_s0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_s0_q <= '0;
      b_s0_q <= '0;
    end else begin
      if (a_acc) a_s0_q <= a_rd;
      if (b_acc) b_s0_q <= b_rd;
    end
  end

  if (ob == 1) begin : g_ob
    logic          a_v0_q, b_v0_q;
    logic [dw-1:0] a_s1_q, b_s1_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        a_v0_q <= 1'b0;
        b_v0_q <= 1'b0;
        a_s1_q <= '0;
        b_s1_q <= '0;
      end else begin
        a_v0_q <= a_acc;
        b_v0_q <= b_acc;
        if (a_v0_q) a_s1_q <= a_s0_q;
        if (b_v0_q) b_s1_q <= b_s0_q;
      end
    end

    assign a.dout = a_s1_q;
    assign b.dout = b_s1_q;
  end else begin : g_no_ob
    assign a.dout = a_s0_q;
    assign b.dout = b_s0_q;
  end

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: drives an ob=0/read-first and an ob=1/write-first copy in lockstep.
module tb_dpram_be;
  import dpram_pkg::*;

`ifdef DPRAM_CLEAR_EN
  localparam int unsigned AW  = 4;
  localparam bit          CLR = 1'b1;
`else
  localparam int unsigned AW  = 10;
  localparam bit          CLR = 1'b0;
`endif
  localparam int unsigned DW    = 32;
  localparam int          DEPTH = 2 ** AW;

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy0, busy1;

  dpram_if #(.aw(AW), .dw(DW)) a0 ();
  dpram_if #(.aw(AW), .dw(DW)) b0 ();
  dpram_if #(.aw(AW), .dw(DW)) a1 ();
  dpram_if #(.aw(AW), .dw(DW)) b1 ();

  dpram_be #(.aw(AW), .dw(DW), .ob(0), .rdw(RDW_READ_FIRST)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .busy(busy0),
    .a   (a0),
    .b   (b0)
  );

  dpram_be #(.aw(AW), .dw(DW), .ob(1), .rdw(RDW_WRITE_FIRST)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .busy(busy1),
    .a   (a1),
    .b   (b1)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          errors   = 0;
  int          cyc      = 0;
  int          clr_left = 0;
  bit          last_busy;
  exp_t        sb[$];
  logic [31:0] cur [4];      // expected dout: 0=dut0 A, 1=dut0 B, 2=dut1 A, 3=dut1 B
  logic [31:0] mdl [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_mdl(input int ad);
    if (mdl.exists(ad)) return mdl[ad];
    return 'x;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] dout_of(input int k);
    case (k)
      0:       return a0.dout;
      1:       return b0.dout;
      2:       return a1.dout;
      default: return b1.dout;
    endcase
  endfunction

  task automatic step(input bit r, input bit ace, input logic [3:0] awe, input int aad,
                      input logic [31:0] adi, input bit bce, input logic [3:0] bwe,
                      input int bad, input logic [31:0] bdi);
    int          ta, tb_a;
    bit          bexp;
    logic [31:0] ao, bo;
    exp_t        keep[$];
    ta   = aad % DEPTH;
    tb_a = bad % DEPTH;
    rst = r;
    a0.ce = ace; a0.we = awe; a0.addr = ta[AW-1:0];   a0.din = adi;
    a1.ce = ace; a1.we = awe; a1.addr = ta[AW-1:0];   a1.din = adi;
    b0.ce = bce; b0.we = bwe; b0.addr = tb_a[AW-1:0]; b0.din = bdi;
    b1.ce = bce; b1.we = bwe; b1.addr = tb_a[AW-1:0]; b1.din = bdi;
    bexp = CLR && (r || clr_left > 0);
    #1;
    last_busy = busy0;
    chk("busy0", 32'(busy0), 32'(bexp));
    chk("busy1", 32'(busy1), 32'(bexp));
    if (r) begin
      clr_left = CLR ? DEPTH : 0;
    end else if (bexp) begin
      mdl[DEPTH - clr_left] = 32'h0;
      clr_left--;
    end else begin
      if (ace) begin
        ao = rd_mdl(ta);
        sb.push_back('{due: cyc + 1, idx: 0, val: ao});
        sb.push_back('{due: cyc + 2, idx: 2, val: merge(ao, adi, awe)});
      end
      if (bce) begin
        bo = rd_mdl(tb_a);
        sb.push_back('{due: cyc + 1, idx: 1, val: bo});
        sb.push_back('{due: cyc + 2, idx: 3, val: merge(bo, bdi, bwe)});
      end
      if (bce) mdl[tb_a] = merge(rd_mdl(tb_a), bdi, bwe);
      if (ace) mdl[ta] = merge(rd_mdl(ta), adi, awe);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (r) begin
      sb.delete();
      for (int k = 0; k < 4; k++) cur[k] = 32'h0;
    end else begin
      foreach (sb[i]) begin
        if (sb[i].due <= cyc) cur[sb[i].idx] = sb[i].val;
        else keep.push_back(sb[i]);
      end
      sb = keep;
    end
    for (int k = 0; k < 4; k++)
      if (!$isunknown(cur[k])) chk($sformatf("sb_dout%0d", k), dout_of(k), cur[k]);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 0, 32'h0, 1'b0, 4'h0, 0, 32'h0);
  endtask

  // Steps idle until busy drops; returns the number of steps that saw busy high.
  task automatic wait_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 4 * DEPTH + 8; i++) begin
      idle();
      if (!last_busy) break;
      cnt++;
    end
  endtask

  initial begin
    int n;
    step(1'b1, 1'b0, 4'h0, 0, 32'h0, 1'b0, 4'h0, 0, 32'h0);
    step(1'b1, 1'b0, 4'h0, 0, 32'h0, 1'b0, 4'h0, 0, 32'h0);
    chk("rst_a0", a0.dout, 32'h0);
    chk("rst_b1", b1.dout, 32'h0);
    wait_busy(n);
    chk("init_busy_len", n, CLR ? DEPTH : 0);

    // Basic write then cross-port read, plus ob=1 latency and hold
    step(1'b0, 1'b1, 4'hF, 'h010, 32'hDEADBEEF, 1'b0, 4'h0, 0, 32'h0);
    step(1'b0, 1'b0, 4'h0, 0, 32'h0, 1'b1, 4'h0, 'h010, 32'h0);
    chk("basic_b0", b0.dout, 32'hDEADBEEF);
    chk("pipe_b1_early", b1.dout, 32'h0);
    idle();
    chk("pipe_b1", b1.dout, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) idle();
    chk("hold_b0", b0.dout, 32'hDEADBEEF);
    chk("hold_b1", b1.dout, 32'hDEADBEEF);

    // Byte enables
    step(1'b0, 1'b1, 4'hF, 'h020, 32'h11223344, 1'b0, 4'h0, 0, 32'h0);
    step(1'b0, 1'b1, 4'h5, 'h020, 32'hAABBCCDD, 1'b0, 4'h0, 0, 32'h0);
    step(1'b0, 1'b1, 4'h0, 'h020, 32'h0, 1'b0, 4'h0, 0, 32'h0);
    chk("byte_en", a0.dout, 32'h11BB33DD);

    // Same-port and cross-port read-during-write
    step(1'b0, 1'b1, 4'hF, 'h030, 32'h1, 1'b0, 4'h0, 0, 32'h0);
    step(1'b0, 1'b1, 4'hF, 'h030, 32'h2, 1'b1, 4'h0, 'h030, 32'h0);
    chk("rdw0_a", a0.dout, 32'h1);
    chk("rdw0_b", b0.dout, 32'h1);
    idle();
    chk("rdw1_a", a1.dout, 32'h2);
    chk("rdw1_b", b1.dout, 32'h1);

    // Write collision
    step(1'b0, 1'b1, 4'h3, 'h040, 32'hAAAAAAAA, 1'b1, 4'hF, 'h040, 32'hBBBBBBBB);
    step(1'b0, 1'b1, 4'h0, 'h040, 32'h0, 1'b0, 4'h0, 0, 32'h0);
    chk("collide", a0.dout, 32'hBBBBAAAA);

    // Access during reset is discarded
    step(1'b0, 1'b1, 4'hF, 'h050, 32'hCAFEF00D, 1'b0, 4'h0, 0, 32'h0);
    step(1'b1, 1'b1, 4'hF, 'h050, 32'h12345678, 1'b0, 4'h0, 0, 32'h0);
    wait_busy(n);
    step(1'b0, 1'b0, 4'h0, 0, 32'h0, 1'b1, 4'h0, 'h050, 32'h0);
    chk("rst_discard", b0.dout, CLR ? 32'h0 : 32'hCAFEF00D);

    // Random traffic over a small, fully initialised window
    for (int i = 0; i < 8; i += 2)
      step(1'b0, 1'b1, 4'hF, i, $urandom, 1'b1, 4'hF, i + 1, $urandom);
    for (int i = 0; i < 40; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 7),
           $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 7), $urandom);

    if (CLR) begin
      for (int i = 0; i < DEPTH; i++)
        step(1'b0, 1'b1, 4'hF, i, 32'hFFFFFFFF, 1'b0, 4'h0, 0, 32'h0);
      step(1'b1, 1'b0, 4'h0, 0, 32'h0, 1'b0, 4'h0, 0, 32'h0);
      n = 0;
      for (int i = 0; i < 4 * DEPTH; i++) begin
        step(1'b0, clr_left > 0, 4'hF, i, 32'h5A5A5A5A, clr_left > 0, 4'hF, i + 3, 32'hA5A5A5A5);
        if (!last_busy) break;
        n++;
      end
      chk("clr_busy_len", n, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        step(1'b0, 1'b1, 4'h0, i, 32'h0, 1'b1, 4'h0, DEPTH - 1 - i, 32'h0);
        chk($sformatf("clr_zero_%0d", i), a0.dout, 32'h0);
      end
      step(1'b1, 1'b0, 4'h0, 0, 32'h0, 1'b0, 4'h0, 0, 32'h0);
      for (int i = 0; i < 7; i++) idle();
      step(1'b1, 1'b0, 4'h0, 0, 32'h0, 1'b0, 4'h0, 0, 32'h0);
      wait_busy(n);
      chk("restart_busy_len", n, DEPTH);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dpram_be.md
# dpram_be

Synchronous true dual-port RAM with per-byte write enables, selectable read-during-write behaviour, an optional output pipeline register and an optional post-reset zero-fill sequencer. It is the generalised successor to the team's single-port RAM. It serves as the shared memory between the CPU bus (port A) and a video or DMA engine (port B), and as a generic FPGA block-RAM macro.

## Interface
- `aw`, 10, number of address bits; depth is 2**aw words.
- `dw`, 32, data width; must be a multiple of 8.
- `ob`, 0, output register stages (0 or 1); adds one cycle of read latency.
- `rdw`, 0, same-port read-during-write mode: 0 = read-first (old data), 1 = write-first (new data).

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `busy`  out  1  clear sequence in progress; both ports are ignored while high.
- `a_ce`  in  1  port A enable.
- `a_we`  in  dw/8  port A byte write enables; bit i covers `din[8i+7:8i]`.
- `a_addr`  in  aw  port A address.
- `a_din`  in  dw  port A write data.
- `a_dout`  out  dw  port A read data.
- `b_ce`, `b_we`, `b_addr`, `b_din`, `b_dout`: same as port A, for port B.

## Operation
- **Access**
  - A port accesses memory in a cycle where its `ce` is high and `busy` is low.
  - Every such access is a read.
  - Byte i is also written when `we[i]` is high.
- **Hold**
  - When a port's `ce` is low, its `dout` holds its last value.
  - With `ob=1`, each pipeline stage loads only when the stage before it carried a valid access.
- **Same-port read-during-write**
  - `rdw=0`: `dout` returns the word as it was before the write.
  - `rdw=1`: `dout` returns the merged word, i.e. new bytes where `we` is set and old bytes elsewhere.
- **Cross-port, same address, same cycle**
  - Read on one port while the other port writes: the reading port always gets the old data, in either `rdw` mode.
  - Both ports write: for each byte, port A wins where `a_we[i]` is set; otherwise port B's byte is written if `b_we[i]` is set.
- **Reset**
  - `a_dout` and `b_dout` are set to 0.
  - All pipeline registers are set to 0.
  - Memory contents are unaffected unless `DPRAM_CLEAR_EN` is defined.
- **Address range**: addresses are full-width and wrap naturally; there are no out-of-range addresses.

## Timing
- **Read latency**, measured from the rising edge that samples `ce`/`addr`:
  - `ob=0`: `dout` is valid after that same edge (1 cycle).
  - `ob=1`: `dout` is valid after the following edge (2 cycles).
- **Writes** take effect at the sampling edge.
  - A read at the same address in the next cycle, on either port, returns the new data.
- **Throughput**: each port accepts one access per cycle, continuously; there are no stalls except `busy`.
- **Reset timing**: `rst` sampled high at edge N gives `dout=0` after edge N.
  - An access presented in the same cycle as `rst` is discarded; it neither writes nor updates `dout`.

## Configuration
- **`DPRAM_CLEAR_EN` defined**
  - The zero-fill sequencer is compiled in.
  - `busy` is 1 while `rst` is high.
  - After `rst` deasserts, the sequencer writes 0 to addresses 0 through 2**aw-1, one per cycle, through port A's write path.
  - `busy` drops after the edge that writes the last address, so `busy` stays high for 2**aw cycles after reset.
  - Port accesses are masked while `busy` is high: no writes happen and `dout` is not updated.
  - `rst` asserted during a clear restarts the clear from address 0.
- **`DPRAM_CLEAR_EN` undefined**
  - `busy` is tied to 0.
  - Memory powers up undefined and `rst` never touches it.
  - Ports are usable from the first cycle after reset.

## Structure
- **Package `dpram_pkg`**
  - Constants `RDW_READ_FIRST = 0` and `RDW_WRITE_FIRST = 1`.
  - Function `nbytes(dw)` returning dw/8.
  - Elaboration check function rejecting a `dw` that is not a multiple of 8, or an `ob` greater than 1.
- **Sub-module `dpram_clear_seq`**
  - Present only under `DPRAM_CLEAR_EN`.
  - Contains an aw-bit counter and a done flag.
  - Outputs `busy`, `clr_addr` and `clr_we`.
  - The top-level mux selects the clear path ahead of port A.
- **Memory array** is a single `reg` array with byte-lane write loops, so that it maps to block RAM.

## Test plan
- **Basic read/write** (`ob=0`): A writes 0xDEADBEEF to address 0x010 with `we=4'hF`, then B reads 0x010 → `b_dout=0xDEADBEEF` one cycle after the read edge.
- **Byte enables**: address 0x020 holds 0x11223344; A writes 0xAABBCCDD with `we=4'b0101` → a read returns 0x11BB33DD.
- **Read-during-write**: address 0x030 holds 0x1; port A writes 0x2 and reads the same address.
  - `rdw=0` → `a_dout=0x1`.
  - `rdw=1` → `a_dout=0x2`.
  - Port B reading the same address in the same cycle → `b_dout=0x1` in both modes.
- **Write collision**: A writes 0xAAAAAAAA with `we=4'b0011` and B writes 0xBBBBBBBB with `we=4'hF`, both to 0x040 → a read returns 0xBBBBAAAA.
- **Pipeline and hold** (`ob=1`): B reads 0x010 at edge N, then drops `ce`.
  - `b_dout` is still 0 after edge N and equals 0xDEADBEEF after edge N+1.
  - It holds that value for the next 10 cycles.
- **Clear** (`DPRAM_CLEAR_EN`, `aw=4`): fill memory with 0xFF, then pulse `rst`.
  - `busy` stays high for 16 cycles.
  - Accesses issued while busy are ignored.
  - Every address then reads 0.
  - `rst` asserted at clear cycle 7 → the clear restarts and `busy` lasts another 16 cycles.
